// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with valid/ready handshakes on both sides.
//   Single-cycle ops (AND, OR, ADD, XOR, SUB, SRA, SLL, NOR, SRL, SLT, SLTU and the
//   reserved codes) register their result one edge after accept. MUL is an iterative
//   radix-2 shift-add that presents its result WIDTH cycles after accept.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operation request
//   in_ready   block can accept an operation this cycle
//   op         4-bit opcode
//   a, b       operands (shift amount taken from b[SHW-1:0])
//   out_valid  result/flags valid, held until out_ready
//   out_ready  consumer takes the result
//   result     registered result
//   zero       registered result == 0
//   overflow   signed overflow (ADD/SUB) or product overflow (MUL)
//   carry_out  ADD carry out, SUB no-borrow
module alu_mc #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  typedef enum logic [0:0] {IDLE, MUL_BUSY} state_t;

  state_t state, state_next;

  logic accept, pop, is_mul, last;
  logic [SHW-1:0] shamt;
  logic [WIDTH:0] sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic alu_ov, alu_c;

  logic [2*WIDTH-1:0] mcand, acc, acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     count;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign is_mul = (op == 4'd11);
  assign shamt  = b[SHW-1:0];
  assign last   = (count == SHW'(WIDTH - 1));

  // Multiplicand is shifted left each step so bit 0 of the multiplier always
  // selects the correctly weighted partial product.
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // Single-cycle datapath; the MUL code falls into the default arm but its
  // value is never registered.
  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    alu_c   = 1'b0;
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    case (op)
      4'd0: alu_res = a & b;
      4'd1: alu_res = a | b;
      4'd2: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd3: alu_res = a ^ b;
      4'd4: begin
        alu_res = diff[WIDTH-1:0];
        // Borrow out of the extended subtraction inverted gives a >= b.
        alu_c   = ~diff[WIDTH];
        alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd5:  alu_res = $signed(a) >>> shamt;
      4'd6:  alu_res = a << shamt;
      4'd7:  alu_res = ~(a | b);
      4'd8:  alu_res = a >> shamt;
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept && is_mul) state_next = MUL_BUSY;
      MUL_BUSY: if (last)             state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready);
  end

  // Result/flag registers and multiplier iteration state. An accept implies the
  // previous result is either absent or being popped this edge, so out_valid
  // can simply be overwritten on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand     <= {{WIDTH{1'b0}}, a};
              mplier    <= b;
              acc       <= '0;
              count     <= '0;
              out_valid <= 1'b0;
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              overflow  <= alu_ov;
              carry_out <= alu_c;
              out_valid <= 1'b1;
            end
          end else if (pop) begin
            out_valid <= 1'b0;
          end
        end
        MUL_BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + SHW'(1);
          if (last) begin
            result    <= acc_next[WIDTH-1:0];
            zero      <= (acc_next[WIDTH-1:0] == '0);
            overflow  <= |acc_next[2*WIDTH-1:WIDTH];
            carry_out <= 1'b0;
            out_valid <= 1'b1;
            count     <= '0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             ov;
    logic             c;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   passes;
  int   cyc;
  logic busy_ready_seen;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.name, ".result"}, result, e.res);
        checkOutput({e.name, ".flags"}, {29'd0, zero, overflow, carry_out},
                    {29'd0, e.z, e.ov, e.c});
      end
    end
  end

  // Drives one request starting just after a rising edge, waits (bounded) for
  // in_ready, records the expected response, and returns just after the accept edge.
  task automatic applyStimulus(input logic [3:0] o, input logic [WIDTH-1:0] va,
                               input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] eres,
                               input logic ez, input logic eov, input logic ec,
                               input string name);
    exp_t e;
    int   n;
    op = o; a = va; b = vb; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput({name, ".accept_timeout"}, 32'd0, 32'd1);
    end else begin
      e.res = eres; e.z = ez; e.ov = eov; e.c = ec; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = $urandom_range(15, 0); a = $urandom(); b = $urandom();
  endtask

  // Counts cycles after the accept edge until out_valid (bounded), noting any
  // cycle in which in_ready was high while waiting.
  task automatic waitValid(output int cycles);
    cycles = 0;
    busy_ready_seen = 1'b0;
    while (!out_valid && cycles < 100) begin
      if (in_ready) busy_ready_seen = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    checks = 0; passes = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset.result", result, 32'd0);
    checkOutput("reset.flags", {29'd0, zero, overflow, carry_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle.in_ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(4'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, "add_ovf");
    waitValid(cyc);
    checkOutput("add.latency", cyc, 32'd0);
    applyStimulus(4'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, "add_carry");
    applyStimulus(4'd4, 32'd5, 32'd5, 32'd0, 1, 0, 1, "sub_eq");
    applyStimulus(4'd4, 32'd0, 32'd1, 32'hFFFFFFFF, 0, 0, 0, "sub_borrow");
    applyStimulus(4'd5, 32'h80000000, 32'd4, 32'hF8000000, 0, 0, 0, "sra_neg");
    applyStimulus(4'd5, 32'h80000001, 32'h20, 32'h80000001, 0, 0, 0, "sra_zero_shift");
    applyStimulus(4'd6, 32'd1, 32'h21, 32'h00000002, 0, 0, 0, "sll_mask");
    applyStimulus(4'd8, 32'h80000000, 32'd31, 32'h00000001, 0, 0, 0, "srl");
    applyStimulus(4'd9, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0, "slt");
    applyStimulus(4'd10, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, 0, "sltu");
    applyStimulus(4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, "and");
    applyStimulus(4'd1, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 0, 0, 0, "or");
    applyStimulus(4'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0, 0, "nor");
    applyStimulus(4'd13, 32'd5, 32'd3, 32'd0, 1, 0, 0, "reserved");

    applyStimulus(4'd11, 32'h00010000, 32'h00010000, 32'd0, 1, 1, 0, "mul_ovf");
    waitValid(cyc);
    checkOutput("mul.latency", cyc, 32'd32);
    checkOutput("mul.busy_in_ready", {31'd0, busy_ready_seen}, 32'd0);
    applyStimulus(4'd11, 32'd7, 32'd6, 32'd42, 0, 0, 0, "mul_small");
    waitValid(cyc);
    applyStimulus(4'd11, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 0, 1, 0, "mul_big");
    waitValid(cyc);
    @(posedge clk);
    #1;

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    applyStimulus(4'd2, 32'd3, 32'd4, 32'd7, 0, 0, 0, "add_held");
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold.result", result, 32'd7);
      checkOutput("hold.in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(4'd3, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 0, 0, 0, "xor_pop_accept");
    checkOutput("pop_accept.result", result, 32'h0F0F0F0F);
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply.
    applyStimulus(4'd11, 32'd12345, 32'd678, 32'd8369910, 0, 0, 0, "mul_aborted");
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort.out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort.result", result, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort.in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(4'd2, 32'd1, 32'd1, 32'd2, 0, 0, 0, "add_after_reset");
    repeat (40) @(posedge clk);
    #1;
    checkOutput("drain.scoreboard_empty", sb.size(), 32'd0);
    checkOutput("drain.out_valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
